alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Combined operand-fetch/issue and writeback stage sitting directly upstream of the 16-bit ALU.
- Accepts 32-bit instruction words from fetch over a valid/ready handshake and decodes them.
- Reads an internal 8x16 register file, forwards the ALU result, and drives registered alu_in1/alu_in2/opcode.
- Writes the ALU's wb_data back into the destination register one cycle after issue.
- Detects illegal opcodes, divide-by-zero and the HALT instruction.

Parameters:
DATA_W, 16, operand/register width (matches ALU).
NREG, 8, register count; the instruction format fixes register addresses at 3 bits.
HALT_OP, 6'h3F, opcode that stops the stage without error.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset rst, synchronous, active-low
instr_valid  in  1  fetch has an instruction
instr  in  32  [31:26] op, [25:23] rd, [22:20] rs1, [19:17] rs2, [16] imm_sel, [15:0] imm
instr_ready  out  1  stage accepts instr this cycle
alu_in1  out  16  registered operand 1 (divisor for op 3)
alu_in2  out  16  registered operand 2 (dividend for op 3)
opcode  out  6  registered opcode to ALU
alu_valid  out  1  alu_in*/opcode hold an issued instruction
wb_data  in  16  ALU result, combinational from alu_in*/opcode
halted  out  1  stage is in HALT
illegal_err  out  1  sticky, illegal opcode seen
div_zero_err  out  1  sticky, op 3 issued with operand1 == 0
dbg_addr  in  3  debug register select
dbg_data  out  16  regfile[dbg_addr], combinational

Behaviour:
- Reset (rst==0 at an edge):
  - All regfile entries = 0; alu_in1, alu_in2 = 0; opcode = 0; alu_valid = 0.
  - halted, illegal_err, div_zero_err = 0; ex_rd = 0; state = RUN.
  - Any pending writeback is discarded. Reset overrides all other events.
- FSM states:
  - RUN: instr_ready = 1.
  - HALT: instr_ready = 0, halted = 1. Only reset leaves HALT.
- Accept: instr_valid && instr_ready at edge N.
- Legal op (0x00-0x0C), decoded at edge N:
  - Registers opcode = op and ex_rd = rd.
  - alu_in1 = value(rs1).
  - alu_in2 = imm_sel ? imm : value(rs2).
  - alu_valid = 1 during cycle N+1.
- No accept at an edge: alu_valid <= 0; operand and opcode registers hold their values.
- Operand value(r), lowest priority first:
  - regfile[r];
  - overridden by wb_data when alu_valid && ex_rd == r && r != 0 (forwarding from the in-flight instruction);
  - r0 always reads 0.
- Writeback: at the edge ending a cycle with alu_valid == 1 and ex_rd != 0, regfile[ex_rd] <= wb_data. Writes to r0 are dropped.
- Latency and throughput:
  - Instruction accepted at edge N writes its result at edge N+1.
  - Back-to-back dependent instructions run at 1 instruction/cycle with no stall.
- Illegal op (0x0D-0x3E) at accept:
  - No issue; alu_valid <= 0.
  - illegal_err <= 1; state becomes HALT.
- HALT_OP at accept: no issue, no error; state becomes HALT.
- Op 3 with value(rs1) == 0 (after forwarding) at accept:
  - No issue; alu_valid <= 0.
  - div_zero_err <= 1; state becomes HALT.
- Entering HALT: the writeback of the instruction already in flight at that edge still completes.
- Simultaneous writeback and read of the same register: the forwarded value wins. dbg_data shows the pre-write regfile value.
- All arithmetic is done by the ALU. This stage does no width extension; imm is used unmodified as 16 bits.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD=0 … OP_NOTB=0x0C, OP_HALT=0x3F;
  - instruction field bit positions;
  - FSM state encoding (RUN, HALT).
- One sub-module, alu_regfile:
  - 8x16, two combinational read ports plus debug read port;
  - one synchronous write port; r0 hardwired 0; synchronous active-low clear.
- Decode, forwarding, FSM and issue registers stay in alu_issue_stage.

Test Plan:
1. Reset then ADD r1 = r0 + imm 0x0005, next cycle ADD r2 = r1 + imm 0x0003 (ALU attached) -> second issue alu_in1 = 0x0005 via forwarding; dbg r2 = 0x0008 two cycles later.
2. SUB r3 = r1 - r2 with r1 = 0x0008, r2 = 0x0005 -> opcode = 1, alu_in1 = 0x0008, alu_in2 = 0x0005; regfile r3 = 0x0003.
3. Write to r0 (ADD r0 = r0 + imm 0x1234) -> dbg r0 stays 0x0000; a following read of r0 gives 0.
4. DIV with rs1 = r0 -> div_zero_err = 1, halted = 1, instr_ready = 0, alu_valid = 0 next cycle.
5. Op 0x20 after a valid ADD r4 = imm 0x00FF -> r4 = 0x00FF still written; illegal_err = 1; HALT; further instr_valid ignored.
6. HALT_OP then rst = 0 for one edge mid-stream -> halted = 1 with no error flags; after reset all outputs, flags and registers read 0 and instr_ready = 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback slice: opcodes, instruction
// field layout and the legacy FSM state encoding.
package alu_pkg;

    localparam int RA_W = 3;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_DIV  = 6'h03;
    localparam logic [5:0] OP_NOTB = 6'h0C;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam int OP_LO     = 26;
    localparam int RD_LO     = 23;
    localparam int RS1_LO    = 20;
    localparam int RS2_LO    = 17;
    localparam int IMMSEL_B  = 16;
    localparam int IMM_LO    = 0;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    typedef struct packed {
        logic [5:0]      op;
        logic [RA_W-1:0] rd;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic            imm_sel;
        logic [15:0]     imm;
    } instr_t;

    function automatic instr_t decode(input logic [31:0] w);
        instr_t d;
        d.op      = w[OP_LO +: 6];
        d.rd      = w[RD_LO +: RA_W];
        d.rs1     = w[RS1_LO +: RA_W];
        d.rs2     = w[RS2_LO +: RA_W];
        d.imm_sel = w[IMMSEL_B];
        d.imm     = w[IMM_LO +: 16];
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Fetch handshake plus the operand/result bus between the issue stage and the ALU.
interface alu_issue_stage_if #(parameter int DATA_W = 16);

    logic              instr_valid;
    logic [31:0]       instr;
    logic              instr_ready;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [5:0]        opcode;
    logic              alu_valid;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output instr_valid, instr, wb_data,
        input  instr_ready, alu_in1, alu_in2, opcode, alu_valid
    );

    modport slave (
        input  instr_valid, instr, wb_data,
        output instr_ready, alu_in1, alu_in2, opcode, alu_valid
    );

endinterface

// File: rtl/alu_regfile.sv
// 8x16 register file: two combinational read ports, a debug read port and one
// synchronous write port; r0 is hardwired to zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   ra1_i,
    input  logic [RA_W-1:0]   ra2_i,
    input  logic [RA_W-1:0]   dbg_addr_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    output logic [DATA_W-1:0] dbg_data_o,
    input  logic              we_i,
    input  logic [RA_W-1:0]   wa_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [DATA_W-1:0] mem_q [NREG];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && wa_i != '0) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o      = (ra1_i == '0)      ? '0 : mem_q[ra1_i];
    assign rd2_o      = (ra2_i == '0)      ? '0 : mem_q[ra2_i];
    assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-fetch/issue and writeback stage in front of the 16-bit ALU: decode,
// result forwarding, illegal/div-zero/HALT detection and registered ALU inputs.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int         DATA_W  = 16,
    parameter int         NREG    = 8,
    parameter logic [5:0] HALT_OP = OP_HALT
) (
    input  logic               clk,
    input  logic               rst,
    alu_issue_stage_if.slave   bus,
    output logic               halted,
    output logic               illegal_err,
    output logic               div_zero_err,
    input  logic [RA_W-1:0]    dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    instr_t            ins;
    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] in1_q, in1_d, in2_q, in2_d;
    logic [5:0]        op_q, op_d;
    logic [RA_W-1:0]   ex_rd_q, ex_rd_d;
    logic              valid_q, valid_d;
    logic              ill_q, ill_d, dz_q, dz_d;
    logic [DATA_W-1:0] rf1, rf2, v1, v2;
    logic              accept, legal, div0;

    assign ins = decode(bus.instr);

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_rf (
        .clk        (clk),
        .rst        (rst),
        .ra1_i      (ins.rs1),
        .ra2_i      (ins.rs2),
        .dbg_addr_i (dbg_addr),
        .rd1_o      (rf1),
        .rd2_o      (rf2),
        .dbg_data_o (dbg_data),
        .we_i       (valid_q),
        .wa_i       (ex_rd_q),
        .wd_i       (bus.wb_data)
    );

    // The in-flight result is written at the same edge this instruction reads,
    // so it must be bypassed; r0 is excluded because its write is dropped.
    always_comb begin
        v1 = rf1;
        v2 = rf2;
        if (valid_q && ex_rd_q == ins.rs1 && ins.rs1 != '0) v1 = bus.wb_data;
        if (valid_q && ex_rd_q == ins.rs2 && ins.rs2 != '0) v2 = bus.wb_data;
    end

    assign accept = bus.instr_valid && (state_q == ST_RUN);
    assign legal  = (ins.op <= OP_NOTB);
    assign div0   = (ins.op == OP_DIV) && (v1 == '0);

    always_comb begin
        state_d = state_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        op_d    = op_q;
        ex_rd_d = ex_rd_q;
        valid_d = 1'b0;
        ill_d   = ill_q;
        dz_d    = dz_q;
        if (accept) begin
            if (legal && !div0) begin
                valid_d = 1'b1;
                op_d    = ins.op;
                ex_rd_d = ins.rd;
                in1_d   = v1;
                in2_d   = ins.imm_sel ? DATA_W'(ins.imm) : v2;
            end else if (legal) begin
                dz_d    = 1'b1;
                state_d = ST_HALT;
            end else if (ins.op == HALT_OP) begin
                state_d = ST_HALT;
            end else begin
                ill_d   = 1'b1;
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            in1_q   <= '0;
            in2_q   <= '0;
            op_q    <= '0;
            ex_rd_q <= '0;
            valid_q <= 1'b0;
            ill_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            op_q    <= op_d;
            ex_rd_q <= ex_rd_d;
            valid_q <= valid_d;
            ill_q   <= ill_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.instr_ready = (state_q == ST_RUN);
    assign bus.alu_in1     = in1_q;
    assign bus.alu_in2     = in2_q;
    assign bus.opcode      = op_q;
    assign bus.alu_valid   = valid_q;
    assign halted          = (state_q == ST_HALT);
    assign illegal_err     = ill_q;
    assign div_zero_err    = dz_q;

endmodule
